up_bus_arbiter: RTL and testbench

- Shares one up register bus between NUM_MASTERS requesters: the AXI bridge, an on-chip profile/sequencer, and debug.
- Sits between the masters and the OR-combined register slices (common, channel, and TPL-common slices of the transport layer).
- Grants masters round-robin, with one outstanding transaction at a time.
- Forwards each transaction as a single-cycle slave request, waits for the slave ack, and returns the ack and read data to the granted master.

---
 rtl/up_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_up_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter sharing one up register bus between several masters.
// Define UP_BUS_ARB_TIMEOUT_EN to add the WAIT-state timeout with timeout_err.
module up_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 up_clk,
  input  logic                                 up_rstn,
  input  logic [NUM_MASTERS-1:0]               m_wreq,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_waddr,
  input  logic [NUM_MASTERS*32-1:0]            m_wdata,
  output logic [NUM_MASTERS-1:0]               m_wack,
  input  logic [NUM_MASTERS-1:0]               m_rreq,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_raddr,
  output logic [31:0]                          m_rdata,
  output logic [NUM_MASTERS-1:0]               m_rack,
  output logic                                 s_wreq,
  output logic [ADDRESS_WIDTH-1:0]             s_waddr,
  output logic [31:0]                          s_wdata,
  input  logic                                 s_wack,
  output logic                                 s_rreq,
  output logic [ADDRESS_WIDTH-1:0]             s_raddr,
  input  logic [31:0]                          s_rdata,
  input  logic                                 s_rack,
  output logic [NUM_MASTERS-1:0]               grant,
  output logic                                 timeout_err
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   dir_q, dir_d;
  logic [AW-1:0]          waddr_q, waddr_d;
  logic [AW-1:0]          raddr_q, raddr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0] req;
  logic [IW-1:0]          win;
  logic                   found;
  logic                   ack_ok;
  logic                   expire;

  assign req    = m_wreq | m_rreq;
  assign ack_ok = dir_q ? s_wack : s_rack;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int j;
    j = int'(p) + k;
    if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
    return IW'(j);
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dir_d   = dir_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_ISSUE;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          dir_d        = m_wreq[win];
          if (m_wreq[win]) begin
            waddr_d = m_waddr[int'(win)*AW +: AW];
            wdata_d = m_wdata[int'(win)*32 +: 32];
          end else begin
            raddr_d = m_raddr[int'(win)*AW +: AW];
          end
          ptr_d = (int'(win) == NUM_MASTERS - 1) ? '0 : win + 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ack_ok) begin
          state_d = S_RESP;
          if (!dir_q) rdata_d = s_rdata;
        end else if (expire) begin
          state_d = S_RESP;
          if (!dir_q) rdata_d = 32'hDEADDEAD;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      dir_q   <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dir_q   <= dir_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef UP_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr_q;
  logic          to_q;

  // A matching ack in the expiry cycle wins over the timeout.
  assign expire = (state_q == S_WAIT) && !ack_ok &&
                  (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= (state_q == S_WAIT) ? tmr_q + 1'b1 : '0;
      if (state_q == S_WAIT) to_q <= expire;
    end
  end

  assign timeout_err = (state_q == S_RESP) && to_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign grant   = grant_q;
  assign s_wreq  = (state_q == S_ISSUE) && dir_q;
  assign s_rreq  = (state_q == S_ISSUE) && !dir_q;
  assign s_waddr = waddr_q;
  assign s_raddr = raddr_q;
  assign s_wdata = wdata_q;
  assign m_wack  = (state_q == S_RESP && dir_q) ? grant_q : '0;
  assign m_rack  = (state_q == S_RESP && !dir_q) ? grant_q : '0;
  assign m_rdata = (state_q == S_RESP && !dir_q) ? rdata_q : '0;

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Self-checking bench for up_bus_arbiter: cycle-number transaction model
// plus directed scenarios with hand-computed expectations.
module tb_up_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int TO = 16;

  logic              up_clk = 1'b0;
  logic              up_rstn;
  logic [N-1:0]      m_wreq, m_rreq, m_wack, m_rack;
  logic [N*AW-1:0]   m_waddr, m_raddr;
  logic [N*32-1:0]   m_wdata;
  logic [31:0]       m_rdata;
  logic              s_wreq, s_rreq, s_wack, s_rack;
  logic [AW-1:0]     s_waddr, s_raddr;
  logic [31:0]       s_wdata, s_rdata;
  logic [N-1:0]      grant;
  logic              timeout_err;

  up_bus_arbiter #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 up_clk = ~up_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Slave: acks s_delay cycles after the request; 0 means never.
  int          s_delay = 1;
  int          s_cnt = 0;
  bit          s_is_w;
  logic [31:0] s_rd_val = '0;
  always @(negedge up_clk) begin
    s_wack = 1'b0;
    s_rack = 1'b0;
    if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        if (s_is_w) s_wack = 1'b1;
        else begin
          s_rack  = 1'b1;
          s_rdata = s_rd_val;
        end
      end
    end
    if ((s_wreq || s_rreq) && s_delay > 0) begin
      s_cnt  = s_delay;
      s_is_w = s_wreq;
    end
  end

  // Model: a transaction is described by its capture/issue/ack cycle numbers.
  bit          en = 0;
  bit          mbusy, mwr, mto;
  int          mown, missue, mack, mptr, mi;
  logic [31:0] mrd, lw_d;
  logic [AW-1:0] lw_a, lr_a;

  always @(posedge up_clk) begin
    if (!up_rstn) begin
      en = 1; mbusy = 0; mptr = 0; mack = -1; mto = 0;
      lw_a = '0; lr_a = '0; lw_d = '0; mrd = '0;
    end else if (!mbusy) begin
      for (int k = 0; k < N; k++) begin
        mi = (mptr + k) % N;
        if (!mbusy && (m_wreq[mi] || m_rreq[mi])) begin
          mbusy = 1; mown = mi; mwr = m_wreq[mi];
          missue = cyc + 1; mack = -1; mto = 0;
          if (mwr) begin
            lw_a = m_waddr[mi*AW +: AW];
            lw_d = m_wdata[mi*32 +: 32];
          end else lr_a = m_raddr[mi*AW +: AW];
          mptr = (mi + 1) % N;
        end
      end
    end else if (mack >= 0) begin
      if (cyc == mack + 1) mbusy = 0;
    end else if (cyc > missue) begin
      if ((mwr && s_wack) || (!mwr && s_rack)) begin
        mack = cyc;
        mrd  = s_rdata;
      end
`ifdef UP_BUS_ARB_TIMEOUT_EN
      else if (cyc == missue + TO) begin
        mack = cyc; mto = 1; mrd = 32'hDEADDEAD;
      end
`endif
    end
    cyc++;
  end

  always @(negedge up_clk) begin
    if (en) begin
      bit iss, rsp;
      logic [N-1:0] eg;
      iss = mbusy && (cyc == missue);
      rsp = mbusy && (mack >= 0) && (cyc == mack + 1);
      eg = '0;
      if (mbusy) eg[mown] = 1'b1;
      chk("grant", 32'(grant), 32'(eg));
      chk("s_wreq", 32'(s_wreq), 32'(iss && mwr));
      chk("s_rreq", 32'(s_rreq), 32'(iss && !mwr));
      chk("s_waddr", 32'(s_waddr), 32'(lw_a));
      chk("s_raddr", 32'(s_raddr), 32'(lr_a));
      chk("s_wdata", s_wdata, lw_d);
      chk("m_wack", 32'(m_wack), (rsp && mwr) ? 32'(eg) : 32'd0);
      chk("m_rack", 32'(m_rack), (rsp && !mwr) ? 32'(eg) : 32'd0);
      chk("m_rdata", m_rdata, (rsp && !mwr) ? mrd : 32'd0);
      chk("timeout_err", 32'(timeout_err), 32'(rsp && mto));
    end
  end

  // Logs of slave requests for the literal checks.
  logic [N-1:0]  wg_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            n_rreq = 0;
  logic [AW-1:0] last_raddr;
  always @(negedge up_clk) begin
    if (en && s_wreq) begin
      wg_q.push_back(grant); wa_q.push_back(s_waddr); wd_q.push_back(s_wdata);
    end
    if (en && s_rreq) begin
      n_rreq++; last_raddr = s_raddr;
    end
  end

  task automatic step();
    @(posedge up_clk);
    #1;
  endtask

  task automatic wait_ack(input bit rd, input int idx, input int lim,
                          input string nm, output int hitcyc);
    int n;
    bit hit;
    n = 0; hit = 0; hitcyc = -1;
    while (!hit && n < lim) begin
      @(negedge up_clk);
      n++;
      hit = rd ? m_rack[idx] : m_wack[idx];
    end
    checks++;
    if (hit) hitcyc = cyc;
    else begin
      errors++;
      $display("FAIL %s: no ack within %0d cycles", nm, lim);
    end
  endtask

  int t0, h, hw, hr, nw, n, nbad, nto;

  initial begin
    up_rstn = 0; m_wreq = '0; m_rreq = '0;
    m_waddr = '0; m_raddr = '0; m_wdata = '0;
    s_wack = 0; s_rack = 0; s_rdata = '0;
    step(); step();
    up_rstn = 1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sreq", 32'({s_wreq, s_rreq}), 0);
    chk("rst_rdata", m_rdata, 0);

    // Contention: both masters write continuously.
    s_delay = 1;
    m_waddr[0*AW +: AW] = 14'h0100; m_wdata[0 +: 32] = 32'hA0A0_0000;
    m_waddr[1*AW +: AW] = 14'h0200; m_wdata[32 +: 32] = 32'hB1B1_0001;
    m_wreq = 2'b11;
    nw = 0; n = 0;
    while (nw < 4 && n < 60) begin
      @(negedge up_clk); n++;
      if (m_wack != '0) nw++;
    end
    chk("cont_acks", 32'(nw), 4);
    step();
    m_wreq = '0;
    repeat (3) step();
    chk("cont_nreq", 32'(wg_q.size()), 4);
    for (int i = 0; i < 4 && i < wg_q.size(); i++) begin
      chk("cont_grant", 32'(wg_q[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_addr", 32'(wa_q[i]), (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("cont_data", wd_q[i], (i % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_0001);
    end

    // Read on master 0, slave acks two cycles after s_rreq.
    s_delay = 2; s_rd_val = 32'h1234_5678;
    m_raddr[0 +: AW] = 14'h0010;
    m_rreq[0] = 1'b1; t0 = cyc; n = n_rreq;
    step();
    m_raddr[0 +: AW] = 14'h3FFF;
    wait_ack(1, 0, 20, "rd_rack", h);
    chk("rd_latency", 32'(h - t0), 4);
    chk("rd_rdata", m_rdata, 32'h1234_5678);
    step();
    m_rreq[0] = 1'b0;
    chk("rd_nreq", 32'(n_rreq - n), 1);
    chk("rd_raddr", 32'(last_raddr), 32'h10);
    chk("rd_grant", 32'(grant), 0);

    // Master 1 requests write and read together.
    s_delay = 3; s_rd_val = 32'h55AA_33CC;
    m_waddr[1*AW +: AW] = 14'h0321; m_wdata[32 +: 32] = 32'hCAFE_F00D;
    m_raddr[1*AW +: AW] = 14'h0ABC;
    m_wreq[1] = 1'b1; m_rreq[1] = 1'b1; n = n_rreq;
    wait_ack(0, 1, 20, "both_wack", hw);
    step();
    m_wreq[1] = 1'b0;
    wait_ack(1, 1, 20, "both_rack", hr);
    chk("both_rdata", m_rdata, 32'h55AA_33CC);
    step();
    m_rreq[1] = 1'b0;
    chk("both_order", 32'(hw < hr), 1);
    chk("both_nw", 32'(wa_q.size()), 5);
    chk("both_nr", 32'(n_rreq - n), 1);
    if (wa_q.size() > 0) begin
      chk("both_waddr", 32'(wa_q[wa_q.size()-1]), 32'h321);
      chk("both_wdata", wd_q[wd_q.size()-1], 32'hCAFE_F00D);
    end
    chk("both_raddr", 32'(last_raddr), 32'hABC);

    // Reset while waiting; the slave ack arrives after reset.
    s_delay = 4;
    m_raddr[1*AW +: AW] = 14'h0777;
    m_rreq[1] = 1'b1;
    n = 0;
    while (!s_rreq && n < 10) begin
      @(negedge up_clk); n++;
    end
    chk("rst_issue", 32'(s_rreq), 1);
    step();
    up_rstn = 0; m_rreq = '0;
    step();
    up_rstn = 1;
    nbad = 0;
    repeat (8) begin
      @(negedge up_clk);
      if (m_wack != '0 || m_rack != '0) nbad++;
    end
    chk("rst_noack", 32'(nbad), 0);
    chk("rst_grant2", 32'(grant), 0);
    chk("rst_raddr", 32'(s_raddr), 0);
    step();
    s_delay = 1;
    m_wreq = 2'b11;
    n = 0;
    while (!s_wreq && n < 10) begin
      @(negedge up_clk); n++;
    end
    chk("rst_first", 32'(grant), 1);
    wait_ack(0, 0, 20, "rst_wack0", h);
    step();
    m_wreq[0] = 1'b0;
    wait_ack(0, 1, 20, "rst_wack1", h);
    step();
    m_wreq[1] = 1'b0;
    repeat (2) step();

    // Read that the slave never acknowledges.
    s_delay = 0;
    m_raddr[0 +: AW] = 14'h0042;
    m_rreq[0] = 1'b1; t0 = cyc;
`ifdef UP_BUS_ARB_TIMEOUT_EN
    wait_ack(1, 0, 40, "to_rack", h);
    chk("to_latency", 32'(h - t0), 32'(TO + 2));
    chk("to_rdata", m_rdata, 32'hDEADDEAD);
    chk("to_err", 32'(timeout_err), 1);
    step();
    m_rreq[0] = 1'b0;
    repeat (2) step();
`else
    nbad = 0; nto = 0;
    repeat (40) begin
      @(negedge up_clk);
      if (m_rack != '0) nbad++;
      if (timeout_err) nto++;
    end
    chk("to_noack", 32'(nbad), 0);
    chk("to_noerr", 32'(nto), 0);
    chk("to_stuck", 32'(grant), 1);
    step();
    up_rstn = 0; m_rreq = '0;
    step();
    up_rstn = 1;
    repeat (2) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
